// File: rtl/cmd_dispatch.sv
// cmd_dispatch: command front-end for the PDH core.
// Watches the PS command register for a toggle on bit 31, decodes the target,
// issues a one-cycle en/clr pulse with a held payload, then captures that
// target's callback after CB_WAIT cycles into a PS-readable status word.
// Optional build macro CMD_DISPATCH_PENDING_EN adds a 1-deep pending command slot.
module cmd_dispatch #(
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned CB_WIDTH    = 8,
  parameter int unsigned CB_WAIT     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [31:0]                     cmd_i,
  output logic [NUM_TARGETS-1:0]          en_o,
  output logic [NUM_TARGETS-1:0]          clr_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  input  logic [NUM_TARGETS*CB_WIDTH-1:0] callback_i,
  output logic [31:0]                     status_o
);

  localparam int unsigned CntW = (CB_WAIT > 1) ? $clog2(CB_WAIT) : 1;
  localparam int unsigned AccW = DATA_WIDTH + 4;
  localparam logic [NUM_TARGETS-1:0] OneHot0 = NUM_TARGETS'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                     state_q;
  logic [31:0]                cmd_r;
  logic                       tgl_ref_r;
  logic [2:0]                 sel_q;
  logic                       bad_q;
  logic [CntW-1:0]            cnt_q;

  logic                       st_done_q;
  logic                       st_busy_q;
  logic                       st_err_q;
  logic                       st_ovr_q;
  logic [2:0]                 st_tgt_q;
  logic [CB_WIDTH-1:0]        st_cb_q;

  // Accepted command packed as {clr, sel[2:0], payload}.
  logic [AccW-1:0]            new_acc;
  logic [AccW-1:0]            acc_cmd;
  logic                       acc_vld;
  logic                       acc_clr;
  logic [2:0]                 acc_sel;
  logic                       acc_ok;
  logic                       new_cmd;
  logic                       drop;
  logic [NUM_TARGETS*CB_WIDTH-1:0] cb_shift;
  logic [CB_WIDTH-1:0]        cb_sel;

`ifdef CMD_DISPATCH_PENDING_EN
  logic                       pend_vld_q;
  logic [AccW-1:0]            pend_cmd_q;
  logic                       take_pend;
  logic                       store;
`endif

  // Payload bits above DATA_WIDTH are ignored.
  logic unused_cmd;
  assign unused_cmd = ^(cmd_r[26:0] >> DATA_WIDTH);

  // Command detection, acceptance and callback slice selection.
  always_comb begin
    new_cmd  = cmd_r[31] != tgl_ref_r;
    new_acc  = {cmd_r[30:27], cmd_r[DATA_WIDTH-1:0]};
`ifdef CMD_DISPATCH_PENDING_EN
    take_pend = (state_q == StIdle) && pend_vld_q;
    acc_vld   = (state_q == StIdle) && (pend_vld_q || new_cmd);
    acc_cmd   = pend_vld_q ? pend_cmd_q : new_acc;
    // A slot freed this cycle can take the arriving command.
    store     = new_cmd && ((state_q != StIdle) || pend_vld_q) && (!pend_vld_q || take_pend);
    drop      = new_cmd && (state_q != StIdle) && pend_vld_q;
`else
    acc_vld   = (state_q == StIdle) && new_cmd;
    acc_cmd   = new_acc;
    drop      = new_cmd && (state_q != StIdle);
`endif
    acc_clr  = acc_cmd[AccW-1];
    acc_sel  = acc_cmd[AccW-2:DATA_WIDTH];
    acc_ok   = {29'd0, acc_sel} < NUM_TARGETS;
    cb_shift = callback_i >> (32'(sel_q) * CB_WIDTH);
    cb_sel   = cb_shift[CB_WIDTH-1:0];
  end

  assign status_o = {st_done_q, st_busy_q, st_err_q, st_ovr_q, st_tgt_q, 25'(st_cb_q)};

  // Dispatch FSM with registered pulses, payload and status fields.
  always_ff @(posedge clk) begin
    cmd_r <= cmd_i;
    if (!rst_n) begin
      // Track the current toggle so a pre-set bit does not fire after reset.
      tgl_ref_r <= cmd_i[31];
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      bad_q     <= 1'b0;
      en_o      <= '0;
      clr_o     <= '0;
      data_o    <= '0;
      st_done_q <= 1'b0;
      st_busy_q <= 1'b0;
      st_err_q  <= 1'b0;
      st_ovr_q  <= 1'b0;
      st_tgt_q  <= '0;
      st_cb_q   <= '0;
`ifdef CMD_DISPATCH_PENDING_EN
      pend_vld_q <= 1'b0;
      pend_cmd_q <= '0;
`endif
    end else begin
      tgl_ref_r <= cmd_r[31];
      en_o      <= '0;
      clr_o     <= '0;
      if (drop) st_ovr_q <= 1'b1;
`ifdef CMD_DISPATCH_PENDING_EN
      if (take_pend) pend_vld_q <= 1'b0;
      if (store) begin
        pend_vld_q <= 1'b1;
        pend_cmd_q <= new_acc;
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (acc_vld) begin
            sel_q     <= acc_sel;
            data_o    <= acc_cmd[DATA_WIDTH-1:0];
            st_busy_q <= 1'b1;
            st_ovr_q  <= 1'b0;
            if (acc_ok) begin
              bad_q   <= 1'b0;
              state_q <= StIssue;
              if (acc_clr) clr_o <= OneHot0 << acc_sel;
              else         en_o  <= OneHot0 << acc_sel;
            end else begin
              bad_q   <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StIssue: begin
          cnt_q   <= CntW'(CB_WAIT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            st_done_q <= ~st_done_q;
            st_busy_q <= 1'b0;
            st_err_q  <= 1'b0;
            st_tgt_q  <= sel_q;
            st_cb_q   <= cb_sel;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          // Good commands already committed status on leaving WAIT.
          if (bad_q) begin
            st_done_q <= ~st_done_q;
            st_busy_q <= 1'b0;
            st_err_q  <= 1'b1;
            st_tgt_q  <= sel_q;
            st_cb_q   <= '0;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch: directed plus randomized bench for cmd_dispatch with a
// timestamp-scheduled reference model. Honours CMD_DISPATCH_PENDING_EN.
module tb_cmd_dispatch;

  localparam int unsigned NT     = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned CBW    = 8;
  localparam int unsigned CBWAIT = 4;
  localparam int unsigned CBT    = NT * CBW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    cmd_i;
  logic [NT-1:0]  en_o;
  logic [NT-1:0]  clr_o;
  logic [DW-1:0]  data_o;
  logic [CBT-1:0] callback_i;
  logic [31:0]    status_o;

  always #5 clk = ~clk;

  cmd_dispatch #(
    .NUM_TARGETS(NT),
    .DATA_WIDTH (DW),
    .CB_WIDTH   (CBW),
    .CB_WAIT    (CBWAIT)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_i     (cmd_i),
    .en_o      (en_o),
    .clr_o     (clr_o),
    .data_o    (data_o),
    .callback_i(callback_i),
    .status_o  (status_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the cycle index being observed and scheduled event times.
  int            cyc;
  int            pulse_cyc;
  int            stat_cyc;
  int            idle_from;
  logic          pulse_clr;
  logic [2:0]    job_sel;
  logic          job_bad;
  logic          m_ref, m_done, m_busy, m_err, m_ovr;
  logic [2:0]    m_tgt;
  logic [CBW-1:0] m_cb;
  logic [DW-1:0] m_data;
  logic          pend_v;
  logic [31:0]   pend_cmd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] nc);
    m_ref = nc[31];
    m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    m_tgt = '0; m_cb = '0; m_data = '0;
    pulse_cyc = -1; stat_cyc = -1; idle_from = cyc + 1;
    pend_v = 1'b0; pend_cmd = '0;
    job_sel = '0; job_bad = 1'b0; pulse_clr = 1'b0;
  endtask

  task automatic accept(input logic [31:0] c);
    job_sel = c[29:27];
    m_data  = c[DW-1:0];
    m_busy  = 1'b1;
    m_ovr   = 1'b0;
    if (int'(job_sel) < NT) begin
      job_bad   = 1'b0;
      pulse_cyc = cyc + 1;
      pulse_clr = c[30];
      stat_cyc  = cyc + 1 + CBWAIT;
      idle_from = cyc + CBWAIT + 3;
    end else begin
      job_bad   = 1'b1;
      pulse_cyc = -1;
      stat_cyc  = cyc + 1;
      idle_from = cyc + 2;
    end
  endtask

  // One clock: check this cycle's outputs, drive the next inputs, advance model.
  task automatic step(input logic [31:0] nc, input logic [CBT-1:0] ncb, input logic nrst);
    logic [31:0]    cur;
    logic [NT-1:0]  oh;
    logic [CBT-1:0] sh;
    logic           arrival;
    logic           free;
    @(negedge clk);
    oh = NT'(1) << job_sel;
    check_eq("en", 32'(en_o), (cyc == pulse_cyc && !pulse_clr) ? 32'(oh) : 32'd0);
    check_eq("clr", 32'(clr_o), (cyc == pulse_cyc && pulse_clr) ? 32'(oh) : 32'd0);
    check_eq("data", 32'(data_o), 32'(m_data));
    check_eq("status", status_o, {m_done, m_busy, m_err, m_ovr, m_tgt, 25'(m_cb)});
    cur        = cmd_i;
    cmd_i      = nc;
    callback_i = ncb;
    rst_n      = nrst;
    if (!nrst) begin
      model_reset(nc);
    end else begin
      arrival = cur[31] != m_ref;
      m_ref   = cur[31];
      free    = cyc >= idle_from;
      if (cyc == stat_cyc) begin
        m_done = ~m_done;
        m_busy = 1'b0;
        m_err  = job_bad;
        m_tgt  = job_sel;
        sh     = ncb >> (job_sel * CBW);
        m_cb   = job_bad ? '0 : sh[CBW-1:0];
      end
      if (free && pend_v) begin
        accept(pend_cmd);
        pend_v = arrival;
        if (arrival) pend_cmd = cur;
      end else if (free && arrival) begin
        accept(cur);
      end else if (arrival) begin
`ifdef CMD_DISPATCH_PENDING_EN
        if (!pend_v) begin
          pend_v   = 1'b1;
          pend_cmd = cur;
        end else begin
          m_ovr = 1'b1;
        end
`else
        m_ovr = 1'b1;
`endif
      end
    end
    cyc++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cmd_i, callback_i, 1'b1);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] nc;
    rst_n      = 1'b0;
    cmd_i      = 32'h8000_0000;
    callback_i = '0;
    repeat (2) @(negedge clk);
    cyc = -1;
    model_reset(cmd_i);
    cyc = 0;

    // Reset with toggle pre-set, then release: nothing must fire.
    step(32'h8000_0000, '0, 1'b0);
    step(32'h8000_0000, '0, 1'b1);
    hold(10);
    check_eq("preset_status", status_o, 32'h0);

    // Re-reset with toggle clear so the next write is a new command.
    step(32'h0000_0000, '0, 1'b0);
    step(32'h0000_0000, '0, 1'b1);
    hold(2);

    // Enable target 1 with payload 0xA5.
    step(32'h8800_00A5, 32'h0000_A500, 1'b1);
    hold(12);
    check_eq("en_status", status_o, 32'h8200_00A5);
    check_eq("en_data", 32'(data_o), 32'h0000_00A5);

    // Clear target 1.
    step(32'h4800_0000, '0, 1'b1);
    hold(12);
    check_eq("clr_status", status_o, 32'h0200_0000);

    // Target 7 is out of range.
    step(32'hB800_0001, '0, 1'b1);
    hold(8);
    check_eq("bad_status", status_o, 32'hAE00_0000);

    // Two commands two cycles apart.
    step(32'h0000_0003, 32'h0000_0055, 1'b1);
    hold(1);
    step(32'h8800_0004, 32'h0000_0055, 1'b1);
    hold(16);
`ifdef CMD_DISPATCH_PENDING_EN
    check_eq("pair_status", status_o, 32'h8200_0000);
`else
    check_eq("pair_status", status_o, 32'h1000_0055);
`endif
    step(32'h0800_0006, 32'h0000_0055, 1'b1);
    hold(12);
    check_eq("ovr_clear", 32'(status_o[28]), 32'd0);

    // Reset pulse while waiting for the callback.
    step(32'h9000_0000, 32'h00AA_0000, 1'b1);
    hold(3);
    step(cmd_i, 32'h00AA_0000, 1'b0);
    step(cmd_i, 32'h00AA_0000, 1'b1);
    hold(10);
    check_eq("abort_status", status_o, 32'h0);

    // Randomized traffic: sparse then bursty, with rare resets.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2000; i++) begin
        nc = cmd_i;
        if ($urandom_range(0, (ph == 0) ? 9 : 2) == 0) begin
          r  = $urandom();
          nc = {~cmd_i[31], r[30:0]};
        end
        step(nc, CBT'($urandom()), ($urandom_range(0, 299) != 0));
      end
    end
    hold(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
